fpu_mem_responder: RTL and testbench

Memory-side responder for the FPU controller's buffer requests. It accepts `request_read`/`request_write` pulses, then moves data through a single 32-bit memory port. Reads fill the idle read buffer with a COL_WIDTH-row image strip; writes drain the idle write buffer of COL_WIDTH-2 result rows. It holds `making_request` high until every accepted request has fully completed, and sits between the FPU controller/buffers and the memory arbiter.

---
 rtl/fpu_mem_responder.sv | 243 ++++++++++++++++++++++++
 tb/tb_fpu_mem_responder.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_mem_responder.sv
// Memory-side responder: fills read buffers from memory and drains write buffers to memory.
// Optional FPU_MEM_BYTE_MASK_EN: partial byte enables on the last word of a short write row.
module fpu_mem_responder #(
    parameter int COL_WIDTH        = 10,
    parameter int MEM_BUFFER_WIDTH = 512,
    localparam int ROW_W = $clog2(COL_WIDTH),
    localparam int COL_W = $clog2(MEM_BUFFER_WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             request_read,
    input  logic [31:0]      read_address,
    input  logic [31:0]      rd_stride,
    input  logic             rd_buffer_sel,
    input  logic             request_write,
    input  logic [31:0]      write_address,
    input  logic [16:0]      write_request_size,
    input  logic [31:0]      wr_stride,
    input  logic             wr_buffer_sel,
    output logic             making_request,
    output logic             overrun,
    output logic             rbuf_wr_en,
    output logic             rbuf_sel,
    output logic [ROW_W-1:0] rbuf_row,
    output logic [COL_W-1:0] rbuf_col,
    output logic [31:0]      rbuf_data,
    output logic             wbuf_rd_en,
    output logic             wbuf_sel,
    output logic [ROW_W-1:0] wbuf_row,
    output logic [COL_W-1:0] wbuf_col,
    input  logic [31:0]      wbuf_data,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_be,
    input  logic             mem_ready,
    input  logic             mem_rdata_valid,
    input  logic [31:0]      mem_rdata
);
    typedef enum logic [2:0] {IDLE, WR_FETCH, WR_ISSUE, RD_ISSUE, RD_WAIT, DONE} state_t;

    localparam logic [ROW_W-1:0] RD_LAST = ROW_W'(COL_WIDTH - 1);
    localparam logic [ROW_W-1:0] WR_LAST = ROW_W'(COL_WIDTH - 3);
    localparam logic [16:0]      BUF_BYTES = 17'(MEM_BUFFER_WIDTH);

    state_t           state;
    logic             active, cur_wr;
    logic             rd_pending, wr_pending;
    logic [31:0]      rd_addr_q, rd_stride_q, wr_addr_q, wr_stride_q;
    logic [16:0]      wr_size_q;
    logic             rd_sel_q, wr_sel_q;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [31:0]      row_base;
    logic             wdata_fresh;
    logic [31:0]      wdata_hold;

    logic             rd_busy, wr_busy, pop_wr, pop_rd;
    logic [16:0]      size_cur, col_next, wr_size_clamped;
    logic             last_col, last_row;
    logic [31:0]      base_next, addr_next;
    logic [ROW_W-1:0] row_nxt;
    logic [COL_W-1:0] col_nxt;
    logic [3:0]       word_be;

    assign making_request  = request_read | request_write | rd_pending | wr_pending | active;
    assign rd_busy         = rd_pending | (active & ~cur_wr);
    assign wr_busy         = wr_pending | (active & cur_wr);
    assign pop_wr          = (state == IDLE) && wr_pending;
    assign pop_rd          = (state == IDLE) && !wr_pending && rd_pending;
    assign wr_size_clamped = (write_request_size > BUF_BYTES) ? BUF_BYTES : write_request_size;

    assign size_cur  = cur_wr ? wr_size_q : BUF_BYTES;
    assign col_next  = 17'(col) + 17'd4;
    assign last_col  = col_next >= size_cur;
    assign last_row  = row == (cur_wr ? WR_LAST : RD_LAST);
    assign base_next = row_base + (cur_wr ? wr_stride_q : rd_stride_q);
    assign addr_next = last_col ? base_next : row_base + 32'(col_next);
    assign row_nxt   = last_col ? row + ROW_W'(1) : row;
    assign col_nxt   = last_col ? '0 : col_next[COL_W-1:0];

`ifdef FPU_MEM_BYTE_MASK_EN
    assign word_be = (last_col && wr_size_q[1:0] != 2'd0)
                   ? (4'hF >> (3'd4 - {1'b0, wr_size_q[1:0]})) : 4'hF;
`else
    assign word_be = 4'hF;
`endif

    // Write data arrives the cycle after the fetch; hold it until the command is accepted.
    assign mem_wdata = wdata_fresh ? wbuf_data : wdata_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            active <= 1'b0;
            cur_wr <= 1'b0;
            rd_pending <= 1'b0;
            wr_pending <= 1'b0;
            rd_addr_q <= '0;
            rd_stride_q <= '0;
            rd_sel_q <= 1'b0;
            wr_addr_q <= '0;
            wr_stride_q <= '0;
            wr_size_q <= '0;
            wr_sel_q <= 1'b0;
            overrun <= 1'b0;
            row <= '0;
            col <= '0;
            row_base <= '0;
            wdata_fresh <= 1'b0;
            wdata_hold <= '0;
            rbuf_wr_en <= 1'b0;
            rbuf_sel <= 1'b0;
            rbuf_row <= '0;
            rbuf_col <= '0;
            rbuf_data <= '0;
            wbuf_rd_en <= 1'b0;
            wbuf_sel <= 1'b0;
            wbuf_row <= '0;
            wbuf_col <= '0;
            mem_req <= 1'b0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_be <= '0;
        end else begin
            wbuf_rd_en <= 1'b0;
            rbuf_wr_en <= 1'b0;
            wdata_fresh <= wbuf_rd_en;
            if (wdata_fresh)
                wdata_hold <= wbuf_data;

            if ((request_write && wr_busy) || (request_read && rd_busy))
                overrun <= 1'b1;

            if (request_write && !wr_busy) begin
                wr_pending <= 1'b1;
                wr_addr_q <= write_address;
                wr_stride_q <= wr_stride;
                wr_size_q <= wr_size_clamped;
                wr_sel_q <= wr_buffer_sel;
            end else if (pop_wr) begin
                wr_pending <= 1'b0;
            end

            if (request_read && !rd_busy) begin
                rd_pending <= 1'b1;
                rd_addr_q <= read_address;
                rd_stride_q <= rd_stride;
                rd_sel_q <= rd_buffer_sel;
            end else if (pop_rd) begin
                rd_pending <= 1'b0;
            end

            case (state)
                IDLE: begin
                    row <= '0;
                    col <= '0;
                    if (pop_wr) begin
                        active <= 1'b1;
                        cur_wr <= 1'b1;
                        row_base <= wr_addr_q;
                        if (wr_size_q == 17'd0) begin
                            state <= DONE;
                        end else begin
                            state <= WR_FETCH;
                            wbuf_rd_en <= 1'b1;
                            wbuf_sel <= !wr_sel_q;
                            wbuf_row <= '0;
                            wbuf_col <= '0;
                        end
                    end else if (pop_rd) begin
                        active <= 1'b1;
                        cur_wr <= 1'b0;
                        row_base <= rd_addr_q;
                        state <= RD_ISSUE;
                        mem_req <= 1'b1;
                        mem_we <= 1'b0;
                        mem_addr <= rd_addr_q;
                        mem_be <= 4'hF;
                    end
                end
                WR_FETCH: begin
                    state <= WR_ISSUE;
                    mem_req <= 1'b1;
                    mem_we <= 1'b1;
                    mem_addr <= row_base + 32'(col);
                    mem_be <= word_be;
                end
                WR_ISSUE: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        mem_we <= 1'b0;
                        row <= row_nxt;
                        col <= col_nxt;
                        if (last_col)
                            row_base <= base_next;
                        if (last_col && last_row) begin
                            state <= DONE;
                        end else begin
                            state <= WR_FETCH;
                            wbuf_rd_en <= 1'b1;
                            wbuf_row <= row_nxt;
                            wbuf_col <= col_nxt;
                        end
                    end
                end
                RD_ISSUE: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (mem_rdata_valid) begin
                        rbuf_wr_en <= 1'b1;
                        rbuf_sel <= !rd_sel_q;
                        rbuf_row <= row;
                        rbuf_col <= col;
                        rbuf_data <= mem_rdata;
                        row <= row_nxt;
                        col <= col_nxt;
                        if (last_col)
                            row_base <= base_next;
                        if (last_col && last_row) begin
                            state <= DONE;
                        end else begin
                            state <= RD_ISSUE;
                            mem_req <= 1'b1;
                            mem_addr <= addr_next;
                            mem_be <= 4'hF;
                        end
                    end
                end
                DONE: begin
                    active <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_mem_responder.sv
// Directed bench for fpu_mem_responder with a small buffer geometry (COL_WIDTH=4, 16-byte rows).
module tb_fpu_mem_responder;
    localparam int CW  = 4;
    localparam int MBW = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        request_read, request_write;
    logic [31:0] read_address, rd_stride, write_address, wr_stride;
    logic        rd_buffer_sel, wr_buffer_sel;
    logic [16:0] write_request_size;
    logic        making_request, overrun;
    logic        rbuf_wr_en, rbuf_sel;
    logic [1:0]  rbuf_row, wbuf_row;
    logic [3:0]  rbuf_col, wbuf_col;
    logic [31:0] rbuf_data;
    logic        wbuf_rd_en, wbuf_sel;
    logic [31:0] wbuf_data = 32'h0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic        mem_rdata_valid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    int total = 0;
    int bad = 0;

    fpu_mem_responder #(.COL_WIDTH(CW), .MEM_BUFFER_WIDTH(MBW)) dut (
        .clk(clk), .rst(rst),
        .request_read(request_read), .read_address(read_address), .rd_stride(rd_stride),
        .rd_buffer_sel(rd_buffer_sel),
        .request_write(request_write), .write_address(write_address),
        .write_request_size(write_request_size), .wr_stride(wr_stride),
        .wr_buffer_sel(wr_buffer_sel),
        .making_request(making_request), .overrun(overrun),
        .rbuf_wr_en(rbuf_wr_en), .rbuf_sel(rbuf_sel), .rbuf_row(rbuf_row),
        .rbuf_col(rbuf_col), .rbuf_data(rbuf_data),
        .wbuf_rd_en(wbuf_rd_en), .wbuf_sel(wbuf_sel), .wbuf_row(wbuf_row),
        .wbuf_col(wbuf_col), .wbuf_data(wbuf_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata_valid(mem_rdata_valid),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_pat(input logic [31:0] a);
        return a ^ 32'h5A00_00C3;
    endfunction

    function automatic logic [31:0] wr_pat(input logic sel, input logic [1:0] r, input logic [3:0] c);
        return 32'hD000_0000 | (32'(sel) << 16) | (32'(r) << 8) | 32'(c);
    endfunction

    // Memory returns read data one cycle after accept; write buffer answers one cycle after a read.
    always @(posedge clk) begin
        mem_rdata_valid <= mem_req && mem_ready && !mem_we;
        mem_rdata <= rd_pat(mem_addr);
        if (wbuf_rd_en)
            wbuf_data <= wr_pat(wbuf_sel, wbuf_row, wbuf_col);
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          cyc;
    } mem_t;
    typedef struct {
        logic        sel;
        logic [1:0]  row;
        logic [3:0]  col;
        logic [31:0] data;
    } rb_t;

    mem_t mem_q[$];
    rb_t  rb_q[$];
    int   cyc = 0;
    int   wbuf_cnt = 0;
    int   mr_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_req && mem_ready)
            mem_q.push_back('{mem_we, mem_addr, mem_wdata, mem_be, cyc});
        if (rbuf_wr_en)
            rb_q.push_back('{rbuf_sel, rbuf_row, rbuf_col, rbuf_data});
        if (wbuf_rd_en)
            wbuf_cnt++;
        if (making_request)
            mr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_pulse(input logic rd, input logic [31:0] ra, input logic [31:0] rs,
                            input logic rsel, input logic wr, input logic [31:0] wa,
                            input logic [16:0] wsz, input logic [31:0] ws, input logic wsel);
        @(posedge clk);
        #1;
        request_read = rd;
        read_address = ra;
        rd_stride = rs;
        rd_buffer_sel = rsel;
        request_write = wr;
        write_address = wa;
        write_request_size = wsz;
        wr_stride = ws;
        wr_buffer_sel = wsel;
        @(posedge clk);
        #1;
        request_read = 1'b0;
        request_write = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (making_request && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, making_request}, 32'd0);
    endtask

    initial begin
        int m0, r0, mr0, w0, n;
        logic [31:0] ea;
        rst = 1'b1;
        request_read = 1'b0;
        request_write = 1'b0;
        read_address = '0;
        rd_stride = '0;
        rd_buffer_sel = 1'b0;
        write_address = '0;
        write_request_size = '0;
        wr_stride = '0;
        wr_buffer_sel = 1'b0;
        mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_making_request", {31'd0, making_request}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_rbuf_data", rbuf_data, 32'd0);
        check("rst_ctrl", {10'd0, mem_req, mem_we, mem_be, rbuf_wr_en, rbuf_sel, rbuf_row, rbuf_col,
                           wbuf_rd_en, wbuf_sel, wbuf_row, wbuf_col}, 32'd0);

        // Read strip: 4 rows x 4 words.
        m0 = mem_q.size(); r0 = rb_q.size(); mr0 = mr_cnt;
        do_pulse(1'b1, 32'h100, 32'h40, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        wait_idle(200, "rd_idle");
        check("rd_mr_cycles", mr_cnt - mr0, 35);
        check("rd_mem_count", mem_q.size() - m0, 16);
        check("rd_rbuf_count", rb_q.size() - r0, 16);
        if (mem_q.size() >= m0 + 16 && rb_q.size() >= r0 + 16) begin
            for (int i = 0; i < 16; i++) begin
                ea = 32'h100 + 32'(i / 4) * 32'h40 + 32'((i % 4) * 4);
                check("rd_mem_addr", mem_q[m0 + i].addr, ea);
                check("rd_mem_we", {31'd0, mem_q[m0 + i].we}, 32'd0);
                check("rd_rbuf_pos", {26'd0, rb_q[r0 + i].row, rb_q[r0 + i].col},
                      {26'd0, 2'(i / 4), 4'((i % 4) * 4)});
                check("rd_rbuf_data", rb_q[r0 + i].data, rd_pat(ea));
                check("rd_rbuf_sel", {31'd0, rb_q[r0 + i].sel}, 32'd1);
            end
            check("rd_word_latency", mem_q[m0 + 15].cyc - mem_q[m0].cyc, 30);
        end

        // Write: size 8, stride 0x20, 2 rows x 2 words.
        m0 = mem_q.size(); mr0 = mr_cnt;
        do_pulse(1'b0, 0, 0, 1'b0, 1'b1, 32'h2000, 17'd8, 32'h20, 1'b1);
        wait_idle(100, "wr_idle");
        check("wr_mr_cycles", mr_cnt - mr0, 11);
        check("wr_mem_count", mem_q.size() - m0, 4);
        if (mem_q.size() >= m0 + 4) begin
            for (int k = 0; k < 4; k++) begin
                check("wr_addr", mem_q[m0 + k].addr, 32'h2000 + 32'(k / 2) * 32'h20 + 32'((k % 2) * 4));
                check("wr_data", mem_q[m0 + k].wdata, wr_pat(1'b0, 2'(k / 2), 4'((k % 2) * 4)));
                check("wr_we_be", {27'd0, mem_q[m0 + k].we, mem_q[m0 + k].be}, 32'h1F);
            end
        end

        // Simultaneous read and write: writes first.
        m0 = mem_q.size();
        do_pulse(1'b1, 32'h300, 32'h10, 1'b0, 1'b1, 32'h4000, 17'd4, 32'h8, 1'b0);
        wait_idle(200, "sim_idle");
        check("sim_count", mem_q.size() - m0, 18);
        if (mem_q.size() >= m0 + 18) begin
            check("sim_w0", {mem_q[m0].we, mem_q[m0].addr[30:0]}, {1'b1, 31'h4000});
            check("sim_w1", {mem_q[m0 + 1].we, mem_q[m0 + 1].addr[30:0]}, {1'b1, 31'h4008});
            check("sim_r0", {mem_q[m0 + 2].we, mem_q[m0 + 2].addr[30:0]}, {1'b0, 31'h300});
            check("sim_rlast", mem_q[m0 + 17].addr, 32'h33C);
        end
        check("sim_no_overrun", {31'd0, overrun}, 32'd0);

        // Second read while one is active: dropped, overrun set.
        m0 = mem_q.size();
        do_pulse(1'b1, 32'h800, 32'h40, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        repeat (4) @(posedge clk);
        do_pulse(1'b1, 32'h900, 32'h40, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        @(negedge clk);
        check("ovr_flag", {31'd0, overrun}, 32'd1);
        wait_idle(200, "ovr_idle");
        check("ovr_count", mem_q.size() - m0, 16);
        if (mem_q.size() >= m0 + 16) begin
            check("ovr_first", mem_q[m0].addr, 32'h800);
            check("ovr_last", mem_q[m0 + 15].addr, 32'h8CC);
        end

        // Withheld mem_ready: command stays stable.
        #1 mem_ready = 1'b0;
        m0 = mem_q.size();
        do_pulse(1'b0, 0, 0, 1'b0, 1'b1, 32'h5000, 17'd4, 32'h0, 1'b0);
        n = 0;
        @(negedge clk);
        while (!mem_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            check("stall_req", {31'd0, mem_req}, 32'd1);
            check("stall_addr", mem_addr, 32'h5000);
            check("stall_wdata", mem_wdata, wr_pat(1'b1, 2'd0, 4'd0));
            @(negedge clk);
        end
        @(posedge clk);
        #1 mem_ready = 1'b1;
        wait_idle(100, "stall_idle");
        check("stall_count", mem_q.size() - m0, 2);
        if (mem_q.size() >= m0 + 2) begin
            check("stall_w0", mem_q[m0].wdata, wr_pat(1'b1, 2'd0, 4'd0));
            check("stall_w1", mem_q[m0 + 1].wdata, wr_pat(1'b1, 2'd1, 4'd0));
            check("stall_a1", mem_q[m0 + 1].addr, 32'h5000);
        end

        // Reset mid-read.
        do_pulse(1'b1, 32'hA00, 32'h40, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mrst_making_request", {31'd0, making_request}, 32'd0);
        check("mrst_overrun", {31'd0, overrun}, 32'd0);
        check("mrst_mem_addr", mem_addr, 32'd0);
        check("mrst_mem_wdata", mem_wdata, 32'd0);
        check("mrst_rbuf_data", rbuf_data, 32'd0);
        check("mrst_ctrl", {10'd0, mem_req, mem_we, mem_be, rbuf_wr_en, rbuf_sel, rbuf_row, rbuf_col,
                            wbuf_rd_en, wbuf_sel, wbuf_row, wbuf_col}, 32'd0);
        m0 = mem_q.size(); r0 = rb_q.size();
        repeat (6) @(negedge clk);
        check("mrst_no_rbuf", rb_q.size() - r0, 0);
        check("mrst_no_mem", mem_q.size() - m0, 0);

        // Size 6: last word of each row is partial.
        m0 = mem_q.size();
        do_pulse(1'b0, 0, 0, 1'b0, 1'b1, 32'h6000, 17'd6, 32'h10, 1'b0);
        wait_idle(100, "sz6_idle");
        check("sz6_count", mem_q.size() - m0, 4);
        if (mem_q.size() >= m0 + 4) begin
            check("sz6_be0", {28'd0, mem_q[m0].be}, 32'hF);
`ifdef FPU_MEM_BYTE_MASK_EN
            check("sz6_be1", {28'd0, mem_q[m0 + 1].be}, 32'h3);
            check("sz6_be3", {28'd0, mem_q[m0 + 3].be}, 32'h3);
`else
            check("sz6_be1", {28'd0, mem_q[m0 + 1].be}, 32'hF);
            check("sz6_be3", {28'd0, mem_q[m0 + 3].be}, 32'hF);
`endif
            check("sz6_a1", mem_q[m0 + 1].addr, 32'h6004);
            check("sz6_a2", mem_q[m0 + 2].addr, 32'h6010);
        end

        // Size 0: no traffic, busy for exactly 3 cycles.
        m0 = mem_q.size(); w0 = wbuf_cnt; mr0 = mr_cnt;
        do_pulse(1'b0, 0, 0, 1'b0, 1'b1, 32'h6000, 17'd0, 32'h10, 1'b0);
        wait_idle(20, "sz0_idle");
        check("sz0_mr_cycles", mr_cnt - mr0, 3);
        check("sz0_no_mem", mem_q.size() - m0, 0);
        check("sz0_no_wbuf", wbuf_cnt - w0, 0);

        // Oversized request clamps to the row width.
        m0 = mem_q.size();
        do_pulse(1'b0, 0, 0, 1'b0, 1'b1, 32'h7000, 17'h1FFFF, 32'h100, 1'b0);
        wait_idle(100, "clamp_idle");
        check("clamp_count", mem_q.size() - m0, 8);
        if (mem_q.size() >= m0 + 8) begin
            check("clamp_a3", mem_q[m0 + 3].addr, 32'h700C);
            check("clamp_a4", mem_q[m0 + 4].addr, 32'h7100);
            check("clamp_a7", mem_q[m0 + 7].addr, 32'h710C);
        end

        // Address arithmetic wraps.
        m0 = mem_q.size();
        do_pulse(1'b0, 0, 0, 1'b0, 1'b1, 32'hFFFF_FFFC, 17'd8, 32'h4, 1'b0);
        wait_idle(100, "wrap_idle");
        check("wrap_count", mem_q.size() - m0, 4);
        if (mem_q.size() >= m0 + 4) begin
            check("wrap_a0", mem_q[m0].addr, 32'hFFFF_FFFC);
            check("wrap_a1", mem_q[m0 + 1].addr, 32'h0);
            check("wrap_a2", mem_q[m0 + 2].addr, 32'h0);
            check("wrap_a3", mem_q[m0 + 3].addr, 32'h4);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
